// File: rtl/ahb_arbiter.sv
// ahb_arbiter: two-master, one-slave AHB-Lite arbiter.
//   Master 0 is the instruction port and master 1 is the data port.
//   The grant is combinational, so an uncontended transfer reaches the slave
//   in the same cycle that the master presents it.
//   A master that loses arbitration, or that presents a request while the
//   slave stalls, has its address phase captured in a per-master hold
//   register. It then sees hready=0 until the held request has been issued.
//   Contended cycles alternate between the masters. After reset, master 0
//   wins the first tie.
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   m{0,1}_haddr/hsize/htrans/    master address-phase request
//     hwrite/hwdata               and write data
//   m{0,1}_hrdata/hready/hresp    per-master response
//   s_haddr/hsize/htrans/         shared slave request
//     hwrite/hwdata
//   s_hrdata/hready/hresp         shared slave response
module ahb_arbiter #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [31:0]   m0_haddr,
  input  logic [2:0]    m0_hsize,
  input  logic [1:0]    m0_htrans,
  input  logic          m0_hwrite,
  input  logic [DW-1:0] m0_hwdata,
  output logic [DW-1:0] m0_hrdata,
  output logic          m0_hready,
  output logic          m0_hresp,
  input  logic [31:0]   m1_haddr,
  input  logic [2:0]    m1_hsize,
  input  logic [1:0]    m1_htrans,
  input  logic          m1_hwrite,
  input  logic [DW-1:0] m1_hwdata,
  output logic [DW-1:0] m1_hrdata,
  output logic          m1_hready,
  output logic          m1_hresp,
  output logic [31:0]   s_haddr,
  output logic [2:0]    s_hsize,
  output logic [1:0]    s_htrans,
  output logic          s_hwrite,
  output logic [DW-1:0] s_hwdata,
  input  logic [DW-1:0] s_hrdata,
  input  logic          s_hready,
  input  logic          s_hresp
);

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  // Live master signals gathered into arrays so both masters share one code path.
  logic [31:0] live_addr_s  [2];
  logic [2:0]  live_size_s  [2];
  logic [1:0]  live_write_s;
  logic [1:0]  live_s;
  logic [1:0]  pend_s;
  logic [1:0]  hready_s;
  logic [1:0]  hresp_s;
  logic [1:0]  fwd_s;
  logic        gnt_valid_s;
  logic        gnt_idx_s;
  logic        unused_htrans_lsb_s;

  // Hold registers: one parked address phase per master.
  logic [1:0]  hold_valid_r;
  logic [31:0] hold_addr_r  [2];
  logic [2:0]  hold_size_r  [2];
  logic [1:0]  hold_write_r;

  logic        r_last;
  logic        r_dph_valid;
  logic        r_dph_owner;

  assign live_addr_s[0] = m0_haddr;
  assign live_addr_s[1] = m1_haddr;
  assign live_size_s[0] = m0_hsize;
  assign live_size_s[1] = m1_hsize;
  assign live_write_s   = {m1_hwrite, m0_hwrite};

  // Only htrans[1] matters: SEQ is issued as NONSEQ, and BUSY is treated like IDLE.
  assign unused_htrans_lsb_s = ^{m0_htrans[0], m1_htrans[0]};

  // Per-master ready and response. A held master stalls until its request is issued.
  always_comb begin
    hready_s = 2'b11;
    hresp_s  = 2'b00;
    for (int i = 0; i < 2; i++) begin
      if (hold_valid_r[i]) begin
        hready_s[i] = 1'b0;
      end else if (r_dph_valid && (r_dph_owner == i[0])) begin
        hready_s[i] = s_hready;
      end else begin
        hready_s[i] = 1'b1;
      end
      if (r_dph_valid && (r_dph_owner == i[0])) begin
        hresp_s[i] = s_hresp;
      end else begin
        hresp_s[i] = 1'b0;
      end
    end
  end

  assign live_s = {m1_htrans[1] & hready_s[1], m0_htrans[1] & hready_s[0]};
  assign pend_s = live_s | hold_valid_r;

  // Combinational grant. On a tie the grant goes to the master that was not granted last.
  always_comb begin
    gnt_valid_s = 1'b0;
    gnt_idx_s   = 1'b0;
    if (rst) begin
      gnt_valid_s = 1'b0;
    end else begin
      case (pend_s)
        2'b01:   begin gnt_valid_s = 1'b1; gnt_idx_s = 1'b0;    end
        2'b10:   begin gnt_valid_s = 1'b1; gnt_idx_s = 1'b1;    end
        2'b11:   begin gnt_valid_s = 1'b1; gnt_idx_s = ~r_last; end
        default: begin gnt_valid_s = 1'b0; gnt_idx_s = 1'b0;    end
      endcase
    end
  end

  // Slave address phase: the held request takes priority over the live signals.
  always_comb begin
    s_htrans = gnt_valid_s ? HTRANS_NONSEQ : HTRANS_IDLE;
    if (hold_valid_r[gnt_idx_s]) begin
      s_haddr  = hold_addr_r[gnt_idx_s];
      s_hsize  = hold_size_r[gnt_idx_s];
      s_hwrite = hold_write_r[gnt_idx_s];
    end else begin
      s_haddr  = live_addr_s[gnt_idx_s];
      s_hsize  = live_size_s[gnt_idx_s];
      s_hwrite = live_write_s[gnt_idx_s];
    end
  end

  assign fwd_s[0] = s_hready & gnt_valid_s & ~gnt_idx_s;
  assign fwd_s[1] = s_hready & gnt_valid_s &  gnt_idx_s;

  assign s_hwdata  = r_dph_owner ? m1_hwdata : m0_hwdata;
  assign m0_hrdata = s_hrdata;
  assign m1_hrdata = s_hrdata;
  assign m0_hready = hready_s[0];
  assign m1_hready = hready_s[1];
  assign m0_hresp  = hresp_s[0];
  assign m1_hresp  = hresp_s[1];

  // Arbitration history and data-phase ownership. All three are frozen while the slave stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last      <= 1'b1;
      r_dph_valid <= 1'b0;
      r_dph_owner <= 1'b0;
    end else if (s_hready) begin
      if (gnt_valid_s) begin
        r_last      <= gnt_idx_s;
        r_dph_valid <= 1'b1;
        r_dph_owner <= gnt_idx_s;
      end else begin
        r_dph_valid <= 1'b0;
      end
    end
  end

  // Hold registers: clear when the request is forwarded, and capture a live request that was not forwarded.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_valid_r <= 2'b00;
      hold_write_r <= 2'b00;
      for (int i = 0; i < 2; i++) begin
        hold_addr_r[i] <= 32'h0000_0000;
        hold_size_r[i] <= 3'b000;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (fwd_s[i]) begin
          hold_valid_r[i] <= 1'b0;
        end else if (live_s[i]) begin
          hold_valid_r[i] <= 1'b1;
          hold_addr_r[i]  <= live_addr_s[i];
          hold_size_r[i]  <= live_size_s[i];
          hold_write_r[i] <= live_write_s[i];
        end
      end
    end
  end

endmodule

// File: doc/ahb_arbiter.md
AHB_ARBITER -- requirements
Module: ahb_arbiter

Interface
REQ-001 SHALL have parameter DW, default 32, meaning data bus width in bits for all hwdata/hrdata ports.
REQ-002 SHALL have port clk  input  1  meaning the single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  meaning reset, asynchronous and active-high.
REQ-004 SHALL have ports m{0,1}_haddr  input  32  meaning master address phase (m0 instruction, m1 data).
REQ-005 SHALL have ports m{0,1}_hsize  input  3  meaning master transfer size.
REQ-006 SHALL have ports m{0,1}_htrans  input  2  meaning master transfer type (IDLE=00, BUSY=01, NONSEQ=10, SEQ=11).
REQ-007 SHALL have ports m{0,1}_hwrite  input  1  meaning master write when 1.
REQ-008 SHALL have ports m{0,1}_hwdata  input  DW  meaning master write data, valid in that master's data phase.
REQ-009 SHALL have ports m{0,1}_hrdata, m{0,1}_hready, m{0,1}_hresp  output  DW/1/1  meaning per-master read data, ready and error response.
REQ-010 SHALL have ports s_haddr/s_hsize/s_htrans/s_hwrite/s_hwdata  output  32/3/2/1/DW  meaning shared slave request.
REQ-011 SHALL have ports s_hrdata/s_hready/s_hresp  input  DW/1/1  meaning shared slave response.

Function
REQ-012 Master i SHALL have a live request when mi_htrans[1]=1 and mi_hready=1; its request SHALL be pending when it has a live request or its hold register is valid.
REQ-013 Grant SHALL be combinational: none pending -> no grant; one pending -> that master; both pending -> master != r_last.
REQ-014 Granted master's request (hold register if valid, else live signals) SHALL drive s_haddr/s_hsize/s_hwrite; s_htrans SHALL be 10 (SEQ converted to NONSEQ) when granted, else 00.
REQ-015 At a rising edge with s_hready=1 and a grant: r_last <= granted index, r_dph_valid <= 1, r_dph_owner <= granted index, granted hold register cleared.
REQ-016 At a rising edge with s_hready=1 and no grant: r_dph_valid <= 0; s_hready=0 SHALL freeze r_last, r_dph_valid, r_dph_owner.
REQ-017 A live request not forwarded at that edge (not granted, or s_hready=0) SHALL be captured into that master's hold register (haddr, hsize, hwrite), hold_valid <= 1.
REQ-018 mi_hready SHALL be: 0 when hold_valid_i; s_hready when r_dph_valid and r_dph_owner=i; else 1.
REQ-019 mi_hresp SHALL equal s_hresp when r_dph_valid and r_dph_owner=i, else 0.
REQ-020 s_hwdata SHALL equal m{r_dph_owner}_hwdata; m0_hrdata and m1_hrdata SHALL both equal s_hrdata.
REQ-021 Uncontended transfers SHALL add zero cycles of latency; a losing master SHALL be issued no later than the next s_hready=1 edge after the winner.
REQ-022 Each master SHALL have at most one outstanding transfer; hold register never overwritten while valid (guaranteed by REQ-018).
REQ-023 Same-master pipelining: data-phase completion and new live request at one edge SHALL be accepted together (forwarded or held).

Reset
REQ-024 While rst=1: hold_valid_{0,1}=0, r_dph_valid=0, r_dph_owner=0, r_last=1 (m0 wins first tie), no grant, s_htrans=00.
REQ-025 While rst=1: m{0,1}_hready=1, m{0,1}_hresp=0; assertion mid-transfer SHALL drop all held and in-flight transfers immediately, without waiting for clk.

Verification
REQ-026 Bench SHALL cover: m1 alone NONSEQ read 0x100, s_hready=1 -> same cycle s_htrans=10, s_haddr=0x100; next cycle m1_hready=1, m1_hrdata=s_hrdata.
REQ-027 Bench SHALL cover: first cycle after reset, m0 read 0x0 and m1 write 0x200 both NONSEQ -> s_haddr=0x0; next cycle s_haddr=0x200, s_hwrite=1, m1_hready=0; following cycle s_hwdata=0xDEADBEEF from m1, m1_hready=1.
REQ-028 Bench SHALL cover: s_hready=0 for 2 cycles in m0 data phase while m1 requests -> m0_hready=0 both cycles, m1 held, m1 issued in the cycle s_hready returns to 1.
REQ-029 Bench SHALL cover: both masters request NONSEQ continuously for 8 transfers -> grants strictly alternate m0,m1,m0,...
REQ-030 Bench SHALL cover: two-cycle error (s_hresp=1, s_hready=0 then 1) on m1 data phase -> m1_hresp=1 both cycles, m0_hresp=0 throughout.
REQ-031 Bench SHALL cover: rst asserted between clock edges while m1 held -> m1_hready=1, s_htrans=00 immediately; after release first tie granted to m0.
